sram_word_bridge: RTL and testbench
===================================

SRAM_WORD_BRIDGE -- requirements
Module: sram_word_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning SRAM byte address width (8K x 8 array).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mem_valid  input  1  bus request; held by initiator until mem_ready.
REQ-005 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-006 SHALL have port mem_addr  input  32  byte address; only bits [ADDR_W-1:2] used.
REQ-007 SHALL have port mem_wdata  input  32  write data, byte i = bits [8i+7:8i].
REQ-008 SHALL have port mem_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-009 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-010 SHALL have port sram_ce  output  1  SRAM clock enable.
REQ-011 SHALL have port sram_oce  output  1  SRAM output-register enable.
REQ-012 SHALL have port sram_reset  output  1  SRAM output reset.
REQ-013 SHALL have port sram_wre  output  1  SRAM write enable.
REQ-014 SHALL have port sram_ad  output  ADDR_W  SRAM byte address.
REQ-015 SHALL have port sram_din  output  8  SRAM write data.
REQ-016 SHALL have port sram_dout  input  8  SRAM read data, valid one cycle after its address is issued with sram_ce=1.

Function
REQ-017 FSM states SHALL be IDLE, READ, READ_LAST, WRITE, DONE.
REQ-018 Cycle 0 = first cycle in IDLE with mem_valid=1; request SHALL be accepted then, latching word address, wdata, wstrb.
REQ-019 mem_valid SHALL be ignored outside IDLE; a drop of mem_valid mid-transaction SHALL NOT abort it.
REQ-020 Byte index i SHALL count 0..3; sram_ad SHALL be {mem_addr[ADDR_W-1:2], i[1:0]} (little-endian lanes).
REQ-021 Read: cycles 1-4 in READ SHALL issue bytes 0..3 with sram_ce=1, sram_wre=0.
REQ-022 Read: sram_dout SHALL be captured into rdata lane i at the end of cycle i+2; cycle 5 is READ_LAST (sram_ce=0, capture lane 3).
REQ-023 Read: mem_ready SHALL be 1 in cycle 6 (DONE) only, with mem_rdata holding all four bytes.
REQ-024 Write: cycles 1-4 in WRITE SHALL issue bytes 0..3, sram_din = wdata lane i, sram_wre = wstrb[i], sram_ce=1.
REQ-025 Write: mem_ready SHALL be 1 in cycle 5 (DONE) only; mem_rdata SHALL be unchanged by writes.
REQ-026 After DONE the FSM SHALL return to IDLE; a request present in that IDLE cycle SHALL be accepted (back-to-back).
REQ-027 sram_ce SHALL be 0 in IDLE, READ_LAST and DONE; sram_wre SHALL be 0 outside WRITE.
REQ-028 sram_oce SHALL be constant 1; sram_reset SHALL equal reset.

Reset
REQ-029 On reset=1 at a clock edge the FSM SHALL enter IDLE, i=0, mem_ready=0, mem_rdata=0, sram_ce=0, sram_wre=0, sram_ad=0, sram_din=0.
REQ-030 Reset mid-transaction SHALL abandon it with no further SRAM write and no mem_ready pulse; bytes already written stay written.

Configuration
REQ-031 Macro SRAM_WORD_BRIDGE_SKIP_EN defined: writes SHALL issue only strobed lanes in ascending order, mem_ready in cycle k+1 for k strobed lanes (k>=1); reads unchanged.
REQ-032 Macro SRAM_WORD_BRIDGE_SKIP_EN undefined: writes SHALL always take four issue cycles per REQ-024/025.

Verification
REQ-033 Write addr 0x0000_0010, wdata 0xA1B2C3D4, wstrb 4'b1111 -> SRAM bytes 0x10..0x13 = D4,C3,B2,A1; mem_ready in cycle 5.
REQ-034 Read addr 0x0000_0010 after REQ-033 -> mem_rdata 0xA1B2C3D4 with mem_ready in cycle 6, single-cycle pulse.
REQ-035 Write addr 0x14 wstrb 4'b0100 wdata 0x00EE0000 over 0x11223344 -> read gives 0x11EE3344; with SKIP_EN mem_ready in cycle 2, otherwise cycle 5.
REQ-036 Addr 0x1FFC and 0x3FFC (bit 13 set) -> both access bytes 0x1FFC..0x1FFF (upper bits ignored, no wrap to 0x0000).
REQ-037 Back-to-back: write then read with mem_valid held through IDLE -> second request accepted in cycle after first DONE, no idle gap.
REQ-038 Assert reset in cycle 2 of a full-strobe write -> only byte 0 (and byte 1 if written at that edge is excluded: byte 0 only) changed, no mem_ready, all outputs at reset values next cycle.

Source files
------------

// File: rtl/sram_word_bridge.sv
// sram_word_bridge: bridges a 32-bit valid/ready word bus onto an 8-bit
// synchronous SRAM. Each request runs as a sequence of byte cycles,
// with byte lanes in little-endian order.
//
// Optional feature macro: SRAM_WORD_BRIDGE_SKIP_EN.
//    When it is defined, writes issue only the strobed lanes, in ascending order.
//    When it is undefined, writes always walk all four lanes.
//
// Read timing, with cycle 0 as the accept cycle:
//    cycles 1-4  READ       issue bytes 0..3
//    cycle  5    READ_LAST  capture lane 3
//    cycle  6    DONE       mem_ready is high
// Write timing:
//    cycles 1-4  WRITE      issue the lanes
//    cycle  5    DONE       mem_ready is high
module sram_word_bridge #(
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_rdata,
   output logic              sram_ce,
   output logic              sram_oce,
   output logic              sram_reset,
   output logic              sram_wre,
   output logic [ADDR_W-1:0] sram_ad,
   output logic [7:0]        sram_din,
   input  logic [7:0]        sram_dout
);

   localparam int WA_W = ADDR_W - 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READ      = 3'd1,
      READ_LAST = 3'd2,
      WRITE     = 3'd3,
      DONE      = 3'd4
   } state_t;

   // Lanes that a write actually issues for a given strobe pattern.
   function automatic logic [3:0] lane_mask(input logic [3:0] strb);
`ifdef SRAM_WORD_BRIDGE_SKIP_EN
      return strb;
`else
      // Every lane issues. A lane with a clear strobe still takes its cycle,
      // but it does so with sram_wre low.
      return strb | 4'b1111;
`endif
   endfunction

   // Returns the lowest enabled lane at or above 'from'.
   // Bit 2 of the result is set when no such lane exists.
   function automatic logic [2:0] next_lane(input logic [3:0] mask, input logic [2:0] from);
      logic [2:0] r;
      r = 3'd4;
      for (int k = 3; k >= 0; k--) begin
         if ((3'(k) >= from) && mask[k]) begin
            r = 3'(k);
         end
      end
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        i_q, i_d;
   logic [WA_W-1:0]   word_q, word_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              ce_q, ce_d;
   logic              wre_q, wre_d;
   logic [ADDR_W-1:0] ad_q, ad_d;
   logic [7:0]        din_q, din_d;
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [2:0]        nl_s;
   logic [1:0]        cap_s;
   logic              unused_addr_bits_s;

   // Only the word address bits reach the SRAM; the remaining bits are ignored.
   assign unused_addr_bits_s = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

   // Next-state and next-output logic. Outputs are precomputed here and then
   // registered, so that each byte cycle drives its own lane.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      ce_d    = 1'b0;
      wre_d   = 1'b0;
      ad_d    = ad_q;
      din_d   = din_q;
      ready_d = 1'b0;
      rdata_d = rdata_q;
      nl_s    = 3'd4;
      cap_s   = 2'd0;
      case (state_q)
         IDLE: begin
            i_d = 2'd0;
            if (mem_valid) begin
               word_d  = mem_addr[ADDR_W-1:2];
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               if (mem_wstrb == 4'b0000) begin
                  state_d = READ;
                  ce_d    = 1'b1;
                  ad_d    = {mem_addr[ADDR_W-1:2], 2'd0};
               end else begin
                  nl_s    = next_lane(lane_mask(mem_wstrb), 3'd0);
                  state_d = WRITE;
                  i_d     = nl_s[1:0];
                  ce_d    = 1'b1;
                  wre_d   = mem_wstrb[nl_s[1:0]];
                  ad_d    = {mem_addr[ADDR_W-1:2], nl_s[1:0]};
                  din_d   = mem_wdata[{nl_s[1:0], 3'b000} +: 8];
               end
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            // sram_dout carries the byte that was issued in the previous cycle.
            if (i_q != 2'd0) begin
               cap_s = i_q - 2'd1;
               rdata_d[{cap_s, 3'b000} +: 8] = sram_dout;
            end else begin
               cap_s = 2'd0;
            end
            if (i_q == 2'd3) begin
               state_d = READ_LAST;
            end else begin
               i_d  = i_q + 2'd1;
               ce_d = 1'b1;
               ad_d = {word_q, i_q + 2'd1};
            end
         end
         READ_LAST: begin
            rdata_d[31:24] = sram_dout;
            state_d        = DONE;
            ready_d        = 1'b1;
         end
         WRITE: begin
            nl_s = next_lane(lane_mask(wstrb_q), {1'b0, i_q} + 3'd1);
            if (nl_s[2]) begin
               state_d = DONE;
               ready_d = 1'b1;
            end else begin
               i_d   = nl_s[1:0];
               ce_d  = 1'b1;
               wre_d = wstrb_q[nl_s[1:0]];
               ad_d  = {word_q, nl_s[1:0]};
               din_d = wdata_q[{nl_s[1:0], 3'b000} +: 8];
            end
         end
         DONE: begin
            state_d = IDLE;
            i_d     = 2'd0;
         end
         default: begin
            state_d = IDLE;
            i_d     = 2'd0;
         end
      endcase
   end

   // State and registered-output flops, with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= 2'd0;
         word_q  <= '0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         ce_q    <= 1'b0;
         wre_q   <= 1'b0;
         ad_q    <= '0;
         din_q   <= 8'd0;
         ready_q <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         ce_q    <= ce_d;
         wre_q   <= wre_d;
         ad_q    <= ad_d;
         din_q   <= din_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   // Reset gates the SRAM strobes at once. This means the byte being issued
   // when reset arrives is never written.
   assign sram_ce    = ce_q & ~reset;
   assign sram_wre   = wre_q & ~reset;
   assign sram_ad    = ad_q;
   assign sram_din   = din_q;
   assign sram_oce   = 1'b1;
   assign sram_reset = reset;
   assign mem_ready  = ready_q;
   assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Directed bench for sram_word_bridge.
// It uses a behavioural 8K x 8 synchronous SRAM with one cycle of read latency.
module tb_sram_word_bridge;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        sram_ce;
   logic        sram_oce;
   logic        sram_reset;
   logic        sram_wre;
   logic [12:0] sram_ad;
   logic [7:0]  sram_din;
   logic [7:0]  sram_dout;

   int errors;
   int checks;

   logic [7:0] sram_mem [0:8191];

   sram_word_bridge #(.ADDR_W(13)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .sram_ce    (sram_ce),
      .sram_oce   (sram_oce),
      .sram_reset (sram_reset),
      .sram_wre   (sram_wre),
      .sram_ad    (sram_ad),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: write-through on wre, registered read data otherwise
   initial begin
      for (int a = 0; a < 8192; a++) sram_mem[a] = 8'h55;
      sram_dout = 8'h00;
   end

   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_wre) sram_mem[sram_ad] <= sram_din;
         else          sram_dout         <= sram_mem[sram_ad];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts a request at the current negedge.
   // It reports the number of posedges until mem_ready is seen (-1 on timeout).
   // It returns at the negedge of the ready cycle, with mem_valid dropped.
   task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output int lat, output logic [31:0] rd);
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      mem_valid = 1'b1;
      lat = -1;
      rd  = 32'hxxxx_xxxx;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (mem_ready === 1'b1) begin
            lat = c;
            rd  = mem_rdata;
         end
      end
      mem_valid = 1'b0;
   endtask

   int          lat;
   logic [31:0] rd;
   int          exp_skip_lat;
   logic        saw_ready;

   initial begin
      errors = 0;
      checks = 0;
`ifdef SRAM_WORD_BRIDGE_SKIP_EN
      exp_skip_lat = 2;
`else
      exp_skip_lat = 5;
`endif
      reset     = 1'b1;
      mem_valid = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wstrb = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      // Values held during reset
      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_ce", 32'(sram_ce), 32'd0);
      chk("rst_wre", 32'(sram_wre), 32'd0);
      chk("rst_ad", 32'(sram_ad), 32'd0);
      chk("rst_din", 32'(sram_din), 32'd0);
      chk("rst_oce", 32'(sram_oce), 32'd1);
      chk("rst_sram_reset", 32'(sram_reset), 32'd1);

      reset = 1'b0;
      @(negedge clk);
      chk("idle_ce", 32'(sram_ce), 32'd0);
      chk("idle_sram_reset", 32'(sram_reset), 32'd0);

      // Full word write to 0x10
      xfer(32'h0000_0010, 32'hA1B2_C3D4, 4'b1111, lat, rd);
      chk("wr10_lat", 32'(lat), 32'd5);
      chk("wr10_rdata_kept", rd, 32'd0);
      chk("wr10_b0", 32'(sram_mem[16]), 32'hD4);
      chk("wr10_b1", 32'(sram_mem[17]), 32'hC3);
      chk("wr10_b2", 32'(sram_mem[18]), 32'hB2);
      chk("wr10_b3", 32'(sram_mem[19]), 32'hA1);
      @(negedge clk);
      chk("wr10_pulse", 32'(mem_ready), 32'd0);

      // Read it back
      xfer(32'h0000_0010, 32'd0, 4'b0000, lat, rd);
      chk("rd10_lat", 32'(lat), 32'd6);
      chk("rd10_data", rd, 32'hA1B2_C3D4);
      @(negedge clk);
      chk("rd10_pulse", 32'(mem_ready), 32'd0);

      // Partial write over a full word
      xfer(32'h0000_0014, 32'h1122_3344, 4'b1111, lat, rd);
      chk("wr14_lat", 32'(lat), 32'd5);
      chk("wr14_rdata_kept", rd, 32'hA1B2_C3D4);
      @(negedge clk);
      xfer(32'h0000_0014, 32'h00EE_0000, 4'b0100, lat, rd);
      chk("wr14_part_lat", 32'(lat), 32'(exp_skip_lat));
      @(negedge clk);
      xfer(32'h0000_0014, 32'd0, 4'b0000, lat, rd);
      chk("rd14_lat", 32'(lat), 32'd6);
      chk("rd14_data", rd, 32'h11EE_3344);
      @(negedge clk);

      // Top of the array, reached through an address with bit 13 set
      xfer(32'h0000_3FFC, 32'hCAFE_BABE, 4'b1111, lat, rd);
      chk("wr3ffc_lat", 32'(lat), 32'd5);
      chk("wr3ffc_b0", 32'(sram_mem[8188]), 32'hBE);
      chk("wr3ffc_b3", 32'(sram_mem[8191]), 32'hCA);
      chk("wr3ffc_nowrap", 32'(sram_mem[0]), 32'h55);
      @(negedge clk);
      xfer(32'h0000_1FFC, 32'd0, 4'b0000, lat, rd);
      chk("rd1ffc_lat", 32'(lat), 32'd6);
      chk("rd1ffc_data", rd, 32'hCAFE_BABE);
      @(negedge clk);
      xfer(32'h0000_3FFC, 32'd0, 4'b0000, lat, rd);
      chk("rd3ffc_data", rd, 32'hCAFE_BABE);
      @(negedge clk);

      // Back-to-back: the read is presented during the write's DONE cycle
      xfer(32'h0000_0018, 32'h5A6B_7C8D, 4'b1111, lat, rd);
      chk("b2b_wr_lat", 32'(lat), 32'd5);
      xfer(32'h0000_0018, 32'd0, 4'b0000, lat, rd);
      chk("b2b_rd_lat", 32'(lat), 32'd7);
      chk("b2b_rd_data", rd, 32'h5A6B_7C8D);
      @(negedge clk);

      // Reset during cycle 2 of a full-strobe write
      mem_addr  = 32'h0000_0020;
      mem_wdata = 32'h4433_2211;
      mem_wstrb = 4'b1111;
      mem_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      mem_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ready", 32'(mem_ready), 32'd0);
      chk("mid_rst_rdata", mem_rdata, 32'd0);
      chk("mid_rst_ce", 32'(sram_ce), 32'd0);
      chk("mid_rst_wre", 32'(sram_wre), 32'd0);
      chk("mid_rst_ad", 32'(sram_ad), 32'd0);
      chk("mid_rst_din", 32'(sram_din), 32'd0);
      reset = 1'b0;
      saw_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (mem_ready === 1'b1) saw_ready = 1'b1;
      end
      chk("mid_rst_no_ready", 32'(saw_ready), 32'd0);
      chk("mid_rst_b0", 32'(sram_mem[32]), 32'h11);
      chk("mid_rst_b1", 32'(sram_mem[33]), 32'h55);
      chk("mid_rst_b2", 32'(sram_mem[34]), 32'h55);
      chk("mid_rst_b3", 32'(sram_mem[35]), 32'h55);

      // The bridge still works after the abandoned transaction
      xfer(32'h0000_0010, 32'd0, 4'b0000, lat, rd);
      chk("post_rst_rd_lat", 32'(lat), 32'd6);
      chk("post_rst_rd_data", rd, 32'hA1B2_C3D4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
